// File: rtl/cute_lock_state_reg_param.sv
// rtl/cute_lock_state_reg_param.sv - key-locked, time-windowed state register for FSM obfuscation
module cute_lock_state_reg_param #(
  parameter int                          STATE_W     = 3,
  parameter int                          KEY_W       = 12,
  parameter int                          NUM_KEYS    = 4,
  parameter int                          WINDOW      = 12,
  parameter logic [NUM_KEYS*KEY_W-1:0]   KEYS        = {12'd2484, 12'd3451, 12'd58, 12'd2213},
  parameter logic [NUM_KEYS*STATE_W-1:0] DECOYS      = {3'd5, 3'd4, 3'd7, 3'd1},
  parameter logic [STATE_W-1:0]          RESET_STATE = STATE_W'(1),
  parameter int                          FAIL_LIMIT  = 0,
  localparam int                         SLOT_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int                         CNT_W       = (NUM_KEYS * WINDOW > 1) ? $clog2(NUM_KEYS * WINDOW) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [KEY_W-1:0]   keyinput,
  input  logic [STATE_W-1:0] nx_state,
  output logic [STATE_W-1:0] pr_state,
  output logic [SLOT_W-1:0]  slot,
  output logic               key_match,
  output logic [7:0]         fail_cnt,
  output logic               locked_out
);

  localparam int TERM = NUM_KEYS * WINDOW - 1;

  generate
    if (NUM_KEYS < 1 || WINDOW < 1 || STATE_W < 1) begin : g_bad_params
      $error("cute_lock_state_reg_param: NUM_KEYS, WINDOW and STATE_W must all be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0]   r_cnt;
  logic [STATE_W-1:0] r_state;
  logic [7:0]         r_fail;
  logic               r_locked;

  logic [KEY_W-1:0]   w_keys   [NUM_KEYS];
  logic [STATE_W-1:0] w_decoys [NUM_KEYS];
  logic [SLOT_W-1:0]  w_slot;
  logic               w_match;
  logic [7:0]         w_fail_next;
  logic               w_lock_next;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_unpack
    assign w_keys[g]   = KEYS[g*KEY_W +: KEY_W];
    assign w_decoys[g] = DECOYS[g*STATE_W +: STATE_W];
  end

  // Divide in int so a WINDOW equal to 2**CNT_W cannot truncate to zero.
  assign w_slot  = SLOT_W'(int'(r_cnt) / WINDOW);
  assign w_match = (keyinput == w_keys[w_slot]);

  always_comb begin
    w_fail_next = r_fail;
    if (!r_locked) begin
      if (w_match)
        w_fail_next = 8'd0;
      else if (r_fail != 8'hFF)
        w_fail_next = r_fail + 8'd1;
    end
  end

  assign w_lock_next = r_locked || ((FAIL_LIMIT != 0) && (int'(w_fail_next) >= FAIL_LIMIT));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_state  <= RESET_STATE;
      r_fail   <= 8'd0;
      r_locked <= 1'b0;
    end else if (en) begin
      r_cnt    <= (int'(r_cnt) == TERM) ? '0 : r_cnt + 1'b1;
      r_state  <= (!r_locked && w_match) ? nx_state : w_decoys[w_slot];
      r_fail   <= w_fail_next;
      r_locked <= w_lock_next;
    end
  end

  assign pr_state   = r_state;
  assign slot       = w_slot;
  assign key_match  = w_match;
  assign fail_cnt   = r_fail;
  assign locked_out = r_locked;

endmodule

// File: tb/tb_cute_lock_state_reg_param.sv
// tb/tb_cute_lock_state_reg_param.sv - directed bench for cute_lock_state_reg_param
module tb_cute_lock_state_reg_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] key;
  logic [2:0]  nx;
  logic [7:0]  key2;
  logic [3:0]  nx2;

  logic [2:0]  p0, p1;
  logic [1:0]  s0, s1, s2;
  logic        km0, km1, km2, l0, l1, l2;
  logic [7:0]  f0, f1, f2;
  logic [3:0]  p2;

  int checks = 0;
  int errors = 0;

  cute_lock_state_reg_param dut0 (
    .clk(clk), .rst(rst), .en(en), .keyinput(key), .nx_state(nx),
    .pr_state(p0), .slot(s0), .key_match(km0), .fail_cnt(f0), .locked_out(l0)
  );

  cute_lock_state_reg_param #(.FAIL_LIMIT(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .keyinput(key), .nx_state(nx),
    .pr_state(p1), .slot(s1), .key_match(km1), .fail_cnt(f1), .locked_out(l1)
  );

  cute_lock_state_reg_param #(
    .STATE_W(4), .KEY_W(8), .NUM_KEYS(3), .WINDOW(5),
    .KEYS({8'h33, 8'h22, 8'h11}), .DECOYS({4'd9, 4'd8, 4'd7}), .RESET_STATE(4'd1)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .keyinput(key2), .nx_state(nx2),
    .pr_state(p2), .slot(s2), .key_match(km2), .fail_cnt(f2), .locked_out(l2)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [11:0] key_for(input int s);
    case (s)
      0: key_for = 12'd2213;
      1: key_for = 12'd58;
      2: key_for = 12'd3451;
      default: key_for = 12'd2484;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; key = 12'd2213; nx = 3'd3; key2 = 8'h11; nx2 = 4'd3;
    rst = 1'b1;
    #1;
    checks++; if (p0 !== 3'd1) begin errors++; $display("FAIL reset_pr got %0d exp 1", p0); end
    checks++; if (s0 !== 2'd0) begin errors++; $display("FAIL reset_slot got %0d exp 0", s0); end
    checks++; if (f0 !== 8'd0) begin errors++; $display("FAIL reset_fail got %0d exp 0", f0); end
    checks++; if (l0 !== 1'b0) begin errors++; $display("FAIL reset_lock got %0d exp 0", l0); end
    checks++; if (km0 !== 1'b1) begin errors++; $display("FAIL reset_match got %0d exp 1", km0); end
    tick();
    checks++; if (p0 !== 3'd1) begin errors++; $display("FAIL reset_hold_pr got %0d exp 1", p0); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++; if (p0 !== 3'd3) begin errors++; $display("FAIL basic_pr edge %0d got %0d exp 3", i, p0); end
    end
    tick();
    checks++; if (p0 !== 3'd7) begin errors++; $display("FAIL basic_decoy got %0d exp 7", p0); end
    checks++; if (f0 !== 8'd1) begin errors++; $display("FAIL basic_fail got %0d exp 1", f0); end
    checks++; if (km0 !== 1'b0) begin errors++; $display("FAIL basic_match got %0d exp 0", km0); end
    checks++; if (s0 !== 2'd1) begin errors++; $display("FAIL basic_slot got %0d exp 1", s0); end
  endtask

  task automatic test_window_wrap();
    int wraps = 0;
    apply_reset();
    for (int e = 0; e < 96; e++) begin
      key = key_for((e % 48) / 12);
      nx  = (e % 2 == 1) ? 3'd6 : 3'd2;
      tick();
      checks++; if (p0 !== nx) begin errors++; $display("FAIL wrap_pr edge %0d got %0d exp %0d", e + 1, p0, nx); end
      checks++; if (f0 !== 8'd0) begin errors++; $display("FAIL wrap_fail edge %0d got %0d exp 0", e + 1, f0); end
      checks++; if (s0 !== 2'(((e + 1) % 48) / 12)) begin
        errors++; $display("FAIL wrap_slot edge %0d got %0d exp %0d", e + 1, s0, ((e + 1) % 48) / 12);
      end
      if (e % 48 == 47 && s0 === 2'd0) wraps++;
    end
    checks++; if (wraps != 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", wraps); end
  endtask

  task automatic test_stall();
    apply_reset();
    key = 12'd2213; nx = 3'd2;
    for (int i = 0; i < 5; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nx = 3'(4 + i % 3);
      tick();
      checks++; if (p0 !== 3'd2) begin errors++; $display("FAIL stall_pr got %0d exp 2", p0); end
    end
    key = 12'd0;
    #1;
    checks++; if (km0 !== 1'b0) begin errors++; $display("FAIL stall_match got %0d exp 0", km0); end
    key = 12'd2213; en = 1'b1; nx = 3'd6;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (p0 !== 3'd6) begin errors++; $display("FAIL stall_resume got %0d exp 6", p0); end
    checks++; if (s0 !== 2'd0) begin errors++; $display("FAIL stall_slot0 got %0d exp 0", s0); end
    tick();
    checks++; if (s0 !== 2'd1) begin errors++; $display("FAIL stall_slot1 got %0d exp 1", s0); end
  endtask

  task automatic test_lockout();
    apply_reset();
    key = 12'd0; nx = 3'd3;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (p1 !== 3'd1) begin errors++; $display("FAIL lock_pr edge %0d got %0d exp 1", i, p1); end
      checks++; if (f1 !== 8'(i)) begin errors++; $display("FAIL lock_fail edge %0d got %0d exp %0d", i, f1, i); end
      checks++; if (l1 !== (i == 3)) begin errors++; $display("FAIL lock_flag edge %0d got %0d exp %0d", i, l1, i == 3); end
    end
    checks++; if (l0 !== 1'b0) begin errors++; $display("FAIL lock_disabled got %0d exp 0", l0); end
    key = 12'd2213;
    for (int i = 4; i <= 12; i++) begin
      tick();
      checks++; if (p1 !== 3'd1) begin errors++; $display("FAIL lock_keep edge %0d got %0d exp 1", i, p1); end
    end
    checks++; if (f1 !== 8'd3) begin errors++; $display("FAIL lock_fail_hold got %0d exp 3", f1); end
    checks++; if (l1 !== 1'b1) begin errors++; $display("FAIL lock_sticky got %0d exp 1", l1); end
    checks++; if (p0 !== 3'd3) begin errors++; $display("FAIL lock_nolimit_pr got %0d exp 3", p0); end
    apply_reset();
    checks++; if (l1 !== 1'b0) begin errors++; $display("FAIL lock_clear got %0d exp 0", l1); end
  endtask

  task automatic test_saturation();
    apply_reset();
    key = 12'd0;
    for (int i = 0; i < 260; i++) tick();
    checks++; if (f0 !== 8'd255) begin errors++; $display("FAIL sat_fail got %0d exp 255", f0); end
    checks++; if (l0 !== 1'b0) begin errors++; $display("FAIL sat_lock got %0d exp 0", l0); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    nx = 3'd2;
    for (int e = 0; e < 30; e++) begin
      key = (e < 28) ? key_for(e / 12) : 12'd0;
      tick();
    end
    checks++; if (p0 !== 3'd4) begin errors++; $display("FAIL async_pre_pr got %0d exp 4", p0); end
    checks++; if (f0 !== 8'd2) begin errors++; $display("FAIL async_pre_fail got %0d exp 2", f0); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (p0 !== 3'd1) begin errors++; $display("FAIL async_pr got %0d exp 1", p0); end
    checks++; if (s0 !== 2'd0) begin errors++; $display("FAIL async_slot got %0d exp 0", s0); end
    checks++; if (f0 !== 8'd0) begin errors++; $display("FAIL async_fail got %0d exp 0", f0); end
    checks++; if (l0 !== 1'b0) begin errors++; $display("FAIL async_lock got %0d exp 0", l0); end
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_small_config();
    key2 = 8'h11; nx2 = 4'hF;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_p;
      tick();
      exp_p = (i <= 5) ? 4'hF : (i <= 10) ? 4'd8 : (i <= 15) ? 4'd9 : 4'hF;
      checks++; if (p2 !== exp_p) begin errors++; $display("FAIL small_pr edge %0d got %0d exp %0d", i, p2, exp_p); end
      if (i == 15) begin
        checks++; if (s2 !== 2'd0) begin errors++; $display("FAIL small_wrap_slot got %0d exp 0", s2); end
        checks++; if (f2 !== 8'd10) begin errors++; $display("FAIL small_fail got %0d exp 10", f2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window_wrap();
    test_stall();
    test_lockout();
    test_saturation();
    test_async_reset();
    test_small_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
